calc_cmd_sequencer: RTL and testbench
=====================================

Name: calc_cmd_sequencer

Overview:
Initiator side of the calculator's key/opcode interface. It accepts high-level commands (clear, enter operand, enter operator) over a valid/ready handshake. It expands each command into the timed opCode/values sequence that the calculator FSM and datapath consume: key code held for HOLD_CYCLES, then the ENTER code held for HOLD_CYCLES, then a NOP gap. It sits between a command source (script ROM, UART decoder or keypad scanner) and the FSM's opCodeIn/values inputs.

Parameters:
HOLD_CYCLES, 5, clock cycles each key code and each ENTER code is driven (≥1)
GAP_CYCLES, 2, clock cycles of NOP_CODE after each command before accepting the next (≥0; 0 = no gap)
NOP_CODE, 3'b111, opCode driven when no key is pressed

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command request
cmd_type  in  2  0=clear, 1=operand, 2=operator(add), 3=illegal
cmd_data  in  4  operand value (used only for cmd_type=1)
cmd_ready  out  1  high when a command can be accepted
opCode  out  3  to FSM opCodeIn: 000 clear, 001 number, 010 enter, 100 add, NOP_CODE idle
values  out  4  to datapath value input
busy  out  1  high while a sequence is in progress (not IDLE)
done  out  1  one-cycle pulse when a sequence completes
err  out  1  one-cycle pulse when an illegal command is accepted

Behaviour:
- Reset (synchronous): state=IDLE, opCode=NOP_CODE, values=0, cmd_ready=1, busy=0, done=0, err=0, hold counter=0. Reset mid-sequence aborts immediately at the next edge. No partial ENTER is emitted afterwards.
- Handshake: accept on the rising edge where cmd_valid && cmd_ready. cmd_type and cmd_data are captured at that edge. cmd_ready=1 only in IDLE. Inputs are ignored while cmd_ready=0, with no queuing.
- States: IDLE, KEY, ENTER, GAP.
- IDLE -> KEY on accept of type 0/1/2. In KEY, opCode is 000 for clear, 001 for operand (values=cmd_data), or 100 for operator.
- KEY lasts exactly HOLD_CYCLES cycles. It then goes to ENTER for operand/operator, or to GAP for clear (clear emits no ENTER).
- ENTER: opCode=010 for exactly HOLD_CYCLES cycles, then GAP.
- GAP: opCode=NOP_CODE for GAP_CYCLES cycles, then IDLE. If GAP_CYCLES=0, the block goes directly to IDLE.
- Type 3 accepted: no phase output and opCode stays NOP_CODE. err pulses for 1 cycle on the cycle after accept. State stays IDLE, and done is not asserted.
- values: loaded with cmd_data on accept of an operand and held (including through ENTER, GAP and IDLE) until the next operand or reset. Clear and operator commands do not change values.
- Latency from the accept edge T:
  - opCode shows the key code from T+1.
  - Operand/operator: busy is high for 2*HOLD_CYCLES+GAP_CYCLES cycles.
  - Clear: busy is high for HOLD_CYCLES+GAP_CYCLES cycles.
- done pulses high in the first IDLE cycle after a sequence, coincident with cmd_ready returning to 1. A new command may be accepted in that same cycle.
- Hold counter is ceil(log2(max(HOLD_CYCLES,GAP_CYCLES)+1)) bits wide. It is reloaded on each state entry and never wraps.
- opCode, values, busy, done and err are all registered outputs, so they are glitch-free into the FSM.

Test Plan:
1. Reset held 5 cycles with cmd_valid=1 -> opCode=3'b111, values=0, cmd_ready=1, busy=0, and no command is accepted.
2. Operand 4 (type 1, data 4'b0100), defaults -> 5 cycles opCode=001 with values=4, then 5 cycles opCode=010, then 2 cycles opCode=111. done pulses at cycle 13 after accept, and values stays 4.
3. Full add script (clear; operand 4; operator; operand 5; operator), with cmd_valid held continuously -> back-to-back sequences each start the cycle done pulses, opCode order is 000,111,001,010,111,100,010,111,001,010,111,100,010,111, and the datapath outValue shows 9.
4. cmd_valid toggling while busy=1 with different data -> ignored: captured values and the sequence are unchanged, with no extra phases.
5. Illegal type 3 -> err pulses for 1 cycle, opCode stays 111, and done=0. A following operand 7 is accepted the next cycle and emits normally.
6. Reset asserted in the 3rd ENTER cycle of an operand sequence -> the next cycle opCode=111, values=0, busy=0, and no done pulse. With HOLD_CYCLES=1 and GAP_CYCLES=0, an operand sequence takes exactly 2 busy cycles.

Source files
------------

// File: rtl/calc_cmd_sequencer.sv
// calc_cmd_sequencer
//   Expands high-level calculator commands into the timed opCode/values
//   sequence the calculator FSM and datapath consume:
//     key code for HOLD_CYCLES, ENTER for HOLD_CYCLES (not for clear),
//     then NOP_CODE for GAP_CYCLES before the next command is accepted.
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready     command handshake (ready only while idle)
//   cmd_type, cmd_data      0=clear 1=operand 2=add 3=illegal; operand value
//   opCode, values          registered drive into FSM opCodeIn / datapath
//   busy, done, err         sequence active, completion pulse, illegal pulse
module calc_cmd_sequencer #(
  parameter int unsigned HOLD_CYCLES = 5,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter logic [2:0]  NOP_CODE    = 3'b111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_type,
  input  logic [3:0] cmd_data,
  output logic       cmd_ready,
  output logic [2:0] opCode,
  output logic [3:0] values,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);

  localparam logic [1:0] T_CLR = 2'd0;
  localparam logic [1:0] T_NUM = 2'd1;
  localparam logic [1:0] T_ILL = 2'd3;

  typedef enum logic [1:0] {IDLE, KEY, ENTER, GAP} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [1:0]     kind, kind_nxt;
  logic [2:0]     op_nxt;
  logic           accept;

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;

  // cnt holds the cycles remaining in the current phase, including this one.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    kind_nxt  = kind;
    case (state)
      IDLE: begin
        if (accept && cmd_type != T_ILL) begin
          state_nxt = KEY;
          cnt_nxt   = CW'(HOLD_CYCLES);
          kind_nxt  = cmd_type;
        end
      end
      KEY: begin
        if (cnt <= CW'(1)) begin
          if (kind != T_CLR) begin
            state_nxt = ENTER;
            cnt_nxt   = CW'(HOLD_CYCLES);
          end else if (GAP_CYCLES == 0) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            state_nxt = GAP;
            cnt_nxt   = CW'(GAP_CYCLES);
          end
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      ENTER: begin
        if (cnt <= CW'(1)) begin
          if (GAP_CYCLES == 0) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            state_nxt = GAP;
            cnt_nxt   = CW'(GAP_CYCLES);
          end
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: begin // GAP
        if (cnt <= CW'(1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
    endcase
  end

  // Output code is decoded from the next state so opCode can be registered
  // and still line up with the phase it belongs to.
  always_comb begin
    op_nxt = NOP_CODE;
    case (state_nxt)
      KEY: begin
        case (kind_nxt)
          T_CLR:   op_nxt = 3'b000;
          T_NUM:   op_nxt = 3'b001;
          default: op_nxt = 3'b100;
        endcase
      end
      ENTER:   op_nxt = 3'b010;
      default: op_nxt = NOP_CODE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      kind   <= T_CLR;
      opCode <= NOP_CODE;
      values <= 4'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      kind   <= kind_nxt;
      opCode <= op_nxt;
      busy   <= (state_nxt != IDLE);
      done   <= (state != IDLE) && (state_nxt == IDLE);
      err    <= accept && (cmd_type == T_ILL);
      // values persists across clear/add so the datapath keeps its operand.
      if (accept && cmd_type == T_NUM)
        values <= cmd_data;
    end
  end

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
module tb_calc_cmd_sequencer;

  localparam int H = 5;
  localparam int G = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic [1:0] cmd_type;
  logic [3:0] cmd_data;
  logic       cmd_ready;
  logic [2:0] opCode;
  logic [3:0] values;
  logic       busy, done, err;

  // second instance: minimum hold, no gap
  logic       r1_valid;
  logic [1:0] r1_type;
  logic [3:0] r1_data;
  logic       r1_ready;
  logic [2:0] r1_op;
  logic [3:0] r1_values;
  logic       r1_busy, r1_done, r1_err;

  int errors = 0;
  int checks = 0;

  logic [3:0] mv = 4'd0;       // model of held values
  bit         rec = 1'b0;
  logic [2:0] tr_op[$];
  logic [3:0] tr_v[$];

  always #5 clk = ~clk;

  calc_cmd_sequencer #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .NOP_CODE(3'b111)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_type(cmd_type),
    .cmd_data(cmd_data), .cmd_ready(cmd_ready), .opCode(opCode), .values(values),
    .busy(busy), .done(done), .err(err)
  );

  calc_cmd_sequencer #(.HOLD_CYCLES(1), .GAP_CYCLES(0), .NOP_CODE(3'b111)) dut1 (
    .clk(clk), .reset(reset), .cmd_valid(r1_valid), .cmd_type(r1_type),
    .cmd_data(r1_data), .cmd_ready(r1_ready), .opCode(r1_op), .values(r1_values),
    .busy(r1_busy), .done(r1_done), .err(r1_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // expected opCode k cycles after the accept edge (k >= 1)
  function automatic logic [2:0] exp_op(input logic [1:0] t, input int k);
    if (t == 2'd0) return (k <= H) ? 3'b000 : 3'b111;
    if (k <= H) return (t == 2'd1) ? 3'b001 : 3'b100;
    if (k <= 2 * H) return 3'b010;
    return 3'b111;
  endfunction

  function automatic int seq_len(input logic [1:0] t);
    if (t == 2'd3) return 0;
    if (t == 2'd0) return H + G;
    return 2 * H + G;
  endfunction

  // Issue one command from an idle point and check every cycle until the
  // first idle cycle after it. toggle=1 scrambles inputs while busy.
  task automatic do_cmd(input logic [1:0] t, input logic [3:0] d, input bit toggle);
    int len;
    len = seq_len(t);
    cmd_valid = 1'b1; cmd_type = t; cmd_data = d;
    check("ready_pre", 32'(cmd_ready), 32'd1);
    step();
    if (t == 2'd1) mv = d;
    for (int k = 1; k <= len; k++) begin
      check("op", 32'(opCode), 32'(exp_op(t, k)));
      check("values", 32'(values), 32'(mv));
      check("busy", 32'(busy), 32'd1);
      check("ready_busy", 32'(cmd_ready), 32'd0);
      check("done_busy", 32'(done), 32'd0);
      check("err_busy", 32'(err), 32'd0);
      if (rec) begin tr_op.push_back(opCode); tr_v.push_back(values); end
      if (toggle) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_type  = 2'($urandom_range(0, 3));
        cmd_data  = 4'($urandom_range(0, 15));
      end
      step();
    end
    check("op_idle", 32'(opCode), 32'h7);
    check("busy_idle", 32'(busy), 32'd0);
    check("ready_idle", 32'(cmd_ready), 32'd1);
    check("done_pulse", 32'(done), (len > 0) ? 32'd1 : 32'd0);
    check("err_pulse", 32'(err), (t == 2'd3) ? 32'd1 : 32'd0);
    check("values_idle", 32'(values), 32'(mv));
    if (rec) begin tr_op.push_back(opCode); tr_v.push_back(values); end
    cmd_valid = 1'b0;
  endtask

  initial begin
    logic [2:0] exp_tr[14];
    logic [2:0] col_op[$];
    logic [3:0] col_v[$];
    int acc;
    bit add_pend;
    int bcnt;

    reset = 1'b1; cmd_valid = 1'b1; cmd_type = 2'd1; cmd_data = 4'd9;
    r1_valid = 1'b0; r1_type = 2'd0; r1_data = 4'd0;

    // 1: reset held with cmd_valid high
    for (int i = 0; i < 5; i++) begin
      step();
      check("rst_op", 32'(opCode), 32'h7);
      check("rst_values", 32'(values), 32'd0);
      check("rst_ready", 32'(cmd_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
    end
    reset = 1'b0; cmd_valid = 1'b0;
    step();
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_values", 32'(values), 32'd0);

    // 2: operand 4
    do_cmd(2'd1, 4'd4, 1'b0);

    // 3: clear; 4; add; 5; add -- back to back
    rec = 1'b1;
    do_cmd(2'd0, 4'd0, 1'b0);
    do_cmd(2'd1, 4'd4, 1'b0);
    do_cmd(2'd2, 4'd0, 1'b0);
    do_cmd(2'd1, 4'd5, 1'b0);
    do_cmd(2'd2, 4'd0, 1'b0);
    rec = 1'b0;
    for (int i = 0; i < tr_op.size(); i++)
      if (i == 0 || tr_op[i] != tr_op[i-1]) begin
        col_op.push_back(tr_op[i]); col_v.push_back(tr_v[i]);
      end
    exp_tr = '{3'b000, 3'b111, 3'b001, 3'b010, 3'b111, 3'b100, 3'b010,
               3'b111, 3'b001, 3'b010, 3'b111, 3'b100, 3'b010, 3'b111};
    check("trace_len", 32'(col_op.size()), 32'd14);
    for (int i = 0; i < 14 && i < col_op.size(); i++)
      check($sformatf("trace[%0d]", i), 32'(col_op[i]), 32'(exp_tr[i]));
    // tiny datapath: clear zeroes, ENTER after number loads or adds
    acc = 0; add_pend = 1'b0;
    for (int i = 0; i < col_op.size(); i++) begin
      if (col_op[i] == 3'b000) begin acc = 0; add_pend = 1'b0; end
      if (col_op[i] == 3'b100) add_pend = 1'b1;
      if (col_op[i] == 3'b010 && i > 0 && col_op[i-1] == 3'b001) begin
        acc = add_pend ? acc + int'(col_v[i]) : int'(col_v[i]);
        add_pend = 1'b0;
      end
    end
    check("out_value", 32'(acc), 32'd9);

    // 4: inputs toggling while busy
    do_cmd(2'd1, 4'd11, 1'b1);
    do_cmd(2'd2, 4'd3, 1'b1);

    // 5: illegal, then operand 7 on the very next cycle
    do_cmd(2'd3, 4'd2, 1'b0);
    do_cmd(2'd1, 4'd7, 1'b0);

    // random commands against the model
    for (int i = 0; i < 30; i++)
      do_cmd(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));

    // 6a: reset in the 3rd ENTER cycle
    cmd_valid = 1'b1; cmd_type = 2'd1; cmd_data = 4'd13;
    step();
    cmd_valid = 1'b0;
    for (int k = 1; k < H + 3; k++) step();
    check("pre_abort_op", 32'(opCode), 32'h2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    mv = 4'd0;
    check("abort_op", 32'(opCode), 32'h7);
    check("abort_values", 32'(values), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("abort_after_op", 32'(opCode), 32'h7);
      check("abort_after_done", 32'(done), 32'd0);
    end

    // 6b: HOLD=1, GAP=0 instance
    r1_valid = 1'b1; r1_type = 2'd1; r1_data = 4'd3;
    step();
    r1_valid = 1'b0;
    bcnt = 0;
    check("h1_op_key", 32'(r1_op), 32'h1);
    check("h1_values", 32'(r1_values), 32'd3);
    for (int i = 0; i < 6 && r1_busy; i++) begin bcnt++; step(); end
    check("h1_busy_len", 32'(bcnt), 32'd2);
    check("h1_done", 32'(r1_done), 32'd1);
    check("h1_ready", 32'(r1_ready), 32'd1);
    check("h1_op_idle", 32'(r1_op), 32'h7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
